// File: rtl/pcs_rx_block_lock.sv
// 64b/66b RX block-lock controller: sync-header lock FSM, gearbox slip request, decoder valid gating.
// Optional high-BER monitor is built when PCS_RX_HI_BER_EN is defined; otherwise out_rx_hi_ber is tied 0.
module pcs_rx_block_lock #(
   parameter int unsigned SH_CNT_LOCK    = 64,
   parameter int unsigned SH_INVALID_MAX = 16,
   parameter int unsigned SLIP_WAIT      = 32,
   parameter int unsigned BER_WINDOW     = 1024,
   parameter int unsigned BER_THRESH     = 16
) (
   input  logic       pcs_clk,
   input  logic       pcs_rst,
   input  logic [1:0] rx_pcs_header,
   input  logic       rx_pcs_valid,
   output logic       out_rx_slip,
   output logic       out_rx_block_lock,
   output logic       out_rx_hi_ber,
   output logic       out_rx_pass_valid
);

   localparam int unsigned SH_W  = $clog2(SH_CNT_LOCK + 1);
   localparam int unsigned INV_W = $clog2(SH_INVALID_MAX + 1);
   localparam int unsigned WT_W  = $clog2(SLIP_WAIT + 1);

   typedef enum logic [1:0] {
      ST_LOCK_INIT,
      ST_TEST_SH,
      ST_SLIP,
      ST_SLIP_WAIT
   } state_t;

   state_t           state;
   logic [SH_W-1:0]  sh_cnt;
   logic [SH_W-1:0]  sh_cnt_inc;
   logic [INV_W-1:0] inv_cnt;
   logic [INV_W-1:0] inv_cnt_inc;
   logic [WT_W-1:0]  wait_cnt;
   logic             sh_bad;
   logic             sh_hit;
   logic             inv_hit;

   // 2'b01 and 2'b10 are the only legal sync headers
   assign sh_bad = ~(rx_pcs_header[1] ^ rx_pcs_header[0]);

   always_comb begin
      sh_cnt_inc  = sh_cnt;
      inv_cnt_inc = inv_cnt;
      if (sh_cnt != SH_W'(SH_CNT_LOCK)) begin
         sh_cnt_inc = sh_cnt + SH_W'(1);
      end
      if (sh_bad && (inv_cnt != INV_W'(SH_INVALID_MAX))) begin
         inv_cnt_inc = inv_cnt + INV_W'(1);
      end
   end

   assign sh_hit  = (sh_cnt_inc == SH_W'(SH_CNT_LOCK));
   assign inv_hit = (inv_cnt_inc == INV_W'(SH_INVALID_MAX));

   always_ff @(posedge pcs_clk) begin
      if (!pcs_rst) begin
         state             <= ST_LOCK_INIT;
         sh_cnt            <= '0;
         inv_cnt           <= '0;
         wait_cnt          <= '0;
         out_rx_slip       <= 1'b0;
         out_rx_block_lock <= 1'b0;
      end else begin
         out_rx_slip <= 1'b0;
         case (state)
            ST_LOCK_INIT: begin
               sh_cnt            <= '0;
               inv_cnt           <= '0;
               wait_cnt          <= '0;
               out_rx_block_lock <= 1'b0;
               state             <= ST_TEST_SH;
            end
            ST_TEST_SH: begin
               if (rx_pcs_valid) begin
                  if (!out_rx_block_lock) begin
                     if (sh_bad) begin
                        out_rx_slip <= 1'b1;
                        sh_cnt      <= '0;
                        inv_cnt     <= '0;
                        state       <= ST_SLIP;
                     end else if (sh_hit && (inv_cnt_inc == '0)) begin
                        out_rx_block_lock <= 1'b1;
                        sh_cnt            <= '0;
                        inv_cnt           <= '0;
                     end else begin
                        sh_cnt  <= sh_cnt_inc;
                        inv_cnt <= inv_cnt_inc;
                     end
                  end else if (inv_hit) begin
                     // invalid limit wins over a coincident end of window
                     out_rx_block_lock <= 1'b0;
                     out_rx_slip       <= 1'b1;
                     sh_cnt            <= '0;
                     inv_cnt           <= '0;
                     state             <= ST_SLIP;
                  end else if (sh_hit) begin
                     sh_cnt  <= '0;
                     inv_cnt <= '0;
                  end else begin
                     sh_cnt  <= sh_cnt_inc;
                     inv_cnt <= inv_cnt_inc;
                  end
               end
            end
            ST_SLIP: begin
               out_rx_block_lock <= 1'b0;
               sh_cnt            <= '0;
               inv_cnt           <= '0;
               wait_cnt          <= WT_W'(SLIP_WAIT - 1);
               state             <= ST_SLIP_WAIT;
            end
            ST_SLIP_WAIT: begin
               if (wait_cnt == '0) begin
                  state <= ST_TEST_SH;
               end else begin
                  wait_cnt <= wait_cnt - WT_W'(1);
               end
            end
            default: state <= ST_LOCK_INIT;
         endcase
      end
   end

`ifdef PCS_RX_HI_BER_EN
   localparam int unsigned WIN_W = $clog2(BER_WINDOW);
   localparam int unsigned BER_W = $clog2(BER_THRESH + 1);

   logic [WIN_W-1:0] win_cnt;
   logic [BER_W-1:0] ber_cnt;
   logic [BER_W-1:0] ber_cnt_inc;
   logic             lock_keep;

   // low on the edge that drops lock, so BER state clears together with lock
   assign lock_keep = out_rx_block_lock &&
                      !((state == ST_TEST_SH) && rx_pcs_valid && inv_hit);

   always_comb begin
      ber_cnt_inc = ber_cnt;
      if ((state == ST_TEST_SH) && rx_pcs_valid && sh_bad &&
          (ber_cnt != BER_W'(BER_THRESH))) begin
         ber_cnt_inc = ber_cnt + BER_W'(1);
      end
   end

   always_ff @(posedge pcs_clk) begin
      if (!pcs_rst || !lock_keep) begin
         win_cnt       <= '0;
         ber_cnt       <= '0;
         out_rx_hi_ber <= 1'b0;
      end else if (win_cnt == WIN_W'(BER_WINDOW - 1)) begin
         win_cnt       <= '0;
         ber_cnt       <= '0;
         out_rx_hi_ber <= (ber_cnt_inc >= BER_W'(BER_THRESH));
      end else begin
         win_cnt <= win_cnt + WIN_W'(1);
         ber_cnt <= ber_cnt_inc;
         if (ber_cnt_inc >= BER_W'(BER_THRESH)) begin
            out_rx_hi_ber <= 1'b1;
         end
      end
   end
`else
   assign out_rx_hi_ber = 1'b0;
`endif

   assign out_rx_pass_valid = rx_pcs_valid & out_rx_block_lock & ~out_rx_hi_ber;

endmodule

// File: tb/tb_pcs_rx_block_lock.sv
// Directed self-checking bench for pcs_rx_block_lock; hi-BER expectations follow PCS_RX_HI_BER_EN.
module tb_pcs_rx_block_lock;

   logic       pcs_clk = 1'b0;
   logic       pcs_rst = 1'b0;
   logic [1:0] rx_pcs_header = 2'b00;
   logic       rx_pcs_valid = 1'b0;
   logic       out_rx_slip;
   logic       out_rx_block_lock;
   logic       out_rx_hi_ber;
   logic       out_rx_pass_valid;

   int total = 0;
   int bad   = 0;

   pcs_rx_block_lock #(
      .SH_CNT_LOCK    (64),
      .SH_INVALID_MAX (16),
      .SLIP_WAIT      (32),
      .BER_WINDOW     (1024),
      .BER_THRESH     (16)
   ) dut (
      .pcs_clk           (pcs_clk),
      .pcs_rst           (pcs_rst),
      .rx_pcs_header     (rx_pcs_header),
      .rx_pcs_valid      (rx_pcs_valid),
      .out_rx_slip       (out_rx_slip),
      .out_rx_block_lock (out_rx_block_lock),
      .out_rx_hi_ber     (out_rx_hi_ber),
      .out_rx_pass_valid (out_rx_pass_valid)
   );

   always #5 pcs_clk = ~pcs_clk;

   function automatic logic [1:0] good_sh(input int i);
      return (i % 2 == 1) ? 2'b10 : 2'b01;
   endfunction

   // drive on the falling edge, sample 1ns after the rising edge that consumed it
   task automatic step(input logic rst_n, input logic v, input logic [1:0] h);
      @(negedge pcs_clk);
      pcs_rst       = rst_n;
      rx_pcs_valid  = v;
      rx_pcs_header = h;
      @(posedge pcs_clk);
      #1;
   endtask

   // leaves the FSM in TEST_SH with no beats counted
   task automatic reset_dut();
      step(1'b0, 1'b0, 2'b00);
      step(1'b0, 1'b0, 2'b00);
      step(1'b1, 1'b0, 2'b00);
   endtask

   task automatic acquire_lock();
      reset_dut();
      for (int i = 1; i <= 64; i++) step(1'b1, 1'b1, good_sh(i));
   endtask

   task automatic test_reset();
      step(1'b0, 1'b0, 2'b00);
      step(1'b0, 1'b1, 2'b01);
      total++;
      if (out_rx_slip !== 1'b0) begin
         bad++; $display("FAIL reset_slip: got %b want 0", out_rx_slip);
      end
      total++;
      if (out_rx_block_lock !== 1'b0) begin
         bad++; $display("FAIL reset_lock: got %b want 0", out_rx_block_lock);
      end
      total++;
      if (out_rx_hi_ber !== 1'b0) begin
         bad++; $display("FAIL reset_hi_ber: got %b want 0", out_rx_hi_ber);
      end
      total++;
      if (out_rx_pass_valid !== 1'b0) begin
         bad++; $display("FAIL reset_pass_valid: got %b want 0", out_rx_pass_valid);
      end
   endtask

   task automatic test_acquire();
      logic exp;
      reset_dut();
      for (int i = 1; i <= 64; i++) begin
         step(1'b1, 1'b1, good_sh(i));
         exp = (i == 64);
         total++;
         if (out_rx_block_lock !== exp) begin
            bad++; $display("FAIL acquire_lock beat %0d: got %b want %b", i, out_rx_block_lock, exp);
         end
         total++;
         if (out_rx_slip !== 1'b0) begin
            bad++; $display("FAIL acquire_slip beat %0d: got %b want 0", i, out_rx_slip);
         end
      end
      step(1'b1, 1'b0, 2'b01);
      total++;
      if (out_rx_pass_valid !== 1'b0) begin
         bad++; $display("FAIL acquire_pass_idle: got %b want 0", out_rx_pass_valid);
      end
      step(1'b1, 1'b1, 2'b10);
      total++;
      if (out_rx_pass_valid !== 1'b1) begin
         bad++; $display("FAIL acquire_pass_valid: got %b want 1", out_rx_pass_valid);
      end
   endtask

   task automatic test_unlocked_bad();
      logic exp;
      reset_dut();
      for (int i = 1; i <= 10; i++) begin
         step(1'b1, 1'b1, (i == 10) ? 2'b00 : good_sh(i));
         exp = (i == 10);
         total++;
         if (out_rx_slip !== exp) begin
            bad++; $display("FAIL unlocked_slip beat %0d: got %b want %b", i, out_rx_slip, exp);
         end
      end
      // slip cycle plus 32 settle cycles: bad headers here must be ignored
      for (int i = 0; i < 33; i++) begin
         step(1'b1, 1'b1, 2'b11);
         total++;
         if (out_rx_slip !== 1'b0) begin
            bad++; $display("FAIL settle_slip cycle %0d: got %b want 0", i, out_rx_slip);
         end
      end
      for (int i = 1; i <= 64; i++) begin
         step(1'b1, 1'b1, good_sh(i));
         exp = (i == 64);
         total++;
         if (out_rx_block_lock !== exp || out_rx_slip !== 1'b0) begin
            bad++; $display("FAIL relock beat %0d: lock=%b slip=%b want lock=%b slip=0", i, out_rx_block_lock, out_rx_slip, exp);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic exp;
      reset_dut();
      for (int s = 1; s <= 70; s++) begin
         step(1'b1, 1'b1, 2'b00);
         exp = (s % 34 == 1);
         total++;
         if (out_rx_slip !== exp) begin
            bad++; $display("FAIL b2b_slip step %0d: got %b want %b", s, out_rx_slip, exp);
         end
      end
   endtask

   task automatic test_lock_loss();
      logic       exp;
      logic [1:0] h;
      acquire_lock();
      for (int i = 1; i <= 64; i++) begin
         step(1'b1, 1'b1, (i <= 15) ? 2'b11 : good_sh(i));
         total++;
         if (out_rx_block_lock !== 1'b1 || out_rx_slip !== 1'b0) begin
            bad++; $display("FAIL hold15_a beat %0d: lock=%b slip=%b want lock=1 slip=0", i, out_rx_block_lock, out_rx_slip);
         end
      end
      for (int i = 1; i <= 64; i++) begin
         step(1'b1, 1'b1, (i >= 50) ? 2'b11 : good_sh(i));
         total++;
         if (out_rx_block_lock !== 1'b1 || out_rx_slip !== 1'b0) begin
            bad++; $display("FAIL hold15_b beat %0d: lock=%b slip=%b want lock=1 slip=0", i, out_rx_block_lock, out_rx_slip);
         end
      end
      // 16th invalid lands on the 64th beat
      for (int i = 1; i <= 64; i++) begin
         h = (i >= 49) ? 2'b11 : good_sh(i);
         step(1'b1, 1'b1, h);
         exp = (i == 64);
         total++;
         if (out_rx_block_lock !== !exp || out_rx_slip !== exp) begin
            bad++; $display("FAIL loss16 beat %0d: lock=%b slip=%b want lock=%b slip=%b", i, out_rx_block_lock, out_rx_slip, !exp, exp);
         end
      end
      step(1'b1, 1'b1, 2'b01);
      total++;
      if (out_rx_slip !== 1'b0 || out_rx_block_lock !== 1'b0) begin
         bad++; $display("FAIL loss_after: slip=%b lock=%b want slip=0 lock=0", out_rx_slip, out_rx_block_lock);
      end
   endtask

   task automatic test_gaps();
      logic exp;
      reset_dut();
      for (int i = 1; i <= 64; i++) begin
         step(1'b1, 1'b1, good_sh(i));
         exp = (i == 64);
         total++;
         if (out_rx_block_lock !== exp) begin
            bad++; $display("FAIL gaps_lock beat %0d: got %b want %b", i, out_rx_block_lock, exp);
         end
         if (i < 64) begin
            step(1'b1, 1'b0, 2'b00);
            total++;
            if (out_rx_block_lock !== 1'b0 || out_rx_slip !== 1'b0) begin
               bad++; $display("FAIL gaps_idle after beat %0d: lock=%b slip=%b want 0 0", i, out_rx_block_lock, out_rx_slip);
            end
         end
      end
      step(1'b1, 1'b0, 2'b01);
      total++;
      if (out_rx_pass_valid !== 1'b0) begin
         bad++; $display("FAIL gaps_pass_idle: got %b want 0", out_rx_pass_valid);
      end
   endtask

   task automatic test_reset_mid();
      logic exp;
      acquire_lock();
      step(1'b0, 1'b1, 2'b01);
      total++;
      if (out_rx_block_lock !== 1'b0 || out_rx_slip !== 1'b0 || out_rx_hi_ber !== 1'b0 ||
          out_rx_pass_valid !== 1'b0) begin
         bad++; $display("FAIL rst_locked: lock=%b slip=%b hi_ber=%b pass=%b want all 0", out_rx_block_lock, out_rx_slip, out_rx_hi_ber, out_rx_pass_valid);
      end
      step(1'b1, 1'b0, 2'b00);
      for (int i = 1; i <= 64; i++) begin
         step(1'b1, 1'b1, good_sh(i));
         exp = (i == 64);
         total++;
         if (out_rx_block_lock !== exp) begin
            bad++; $display("FAIL rst_relock beat %0d: got %b want %b", i, out_rx_block_lock, exp);
         end
      end
      reset_dut();
      step(1'b1, 1'b1, 2'b00);
      total++;
      if (out_rx_slip !== 1'b1) begin
         bad++; $display("FAIL rst_wait_slip: got %b want 1", out_rx_slip);
      end
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 2'b00);
      step(1'b0, 1'b1, 2'b00);
      total++;
      if (out_rx_slip !== 1'b0 || out_rx_block_lock !== 1'b0) begin
         bad++; $display("FAIL rst_in_wait: slip=%b lock=%b want 0 0", out_rx_slip, out_rx_block_lock);
      end
      step(1'b1, 1'b0, 2'b00);
      for (int i = 1; i <= 64; i++) begin
         step(1'b1, 1'b1, good_sh(i));
         exp = (i == 64);
         total++;
         if (out_rx_block_lock !== exp || out_rx_slip !== 1'b0) begin
            bad++; $display("FAIL wait_relock beat %0d: lock=%b slip=%b want lock=%b slip=0", i, out_rx_block_lock, out_rx_slip, exp);
         end
      end
      reset_dut();
      step(1'b0, 1'b1, 2'b00);
      total++;
      if (out_rx_slip !== 1'b0) begin
         bad++; $display("FAIL rst_bad_beat_slip: got %b want 0", out_rx_slip);
      end
   endtask

   task automatic test_hi_ber();
      logic       exp_hi;
      logic [1:0] h;
      acquire_lock();
      for (int k = 0; k < 2048; k++) begin
         h = ((k % 32 == 31) && (k < 512)) ? 2'b11 : good_sh(k);
         step(1'b1, 1'b1, h);
         if (k == 510 || k == 511 || k == 1023 || k == 1024 || k == 2046 || k == 2047) begin
`ifdef PCS_RX_HI_BER_EN
            exp_hi = (k >= 511) && (k < 2047);
`else
            exp_hi = 1'b0;
`endif
            total++;
            if (out_rx_hi_ber !== exp_hi) begin
               bad++; $display("FAIL hi_ber k=%0d: got %b want %b", k, out_rx_hi_ber, exp_hi);
            end
            total++;
            if (out_rx_pass_valid !== !exp_hi) begin
               bad++; $display("FAIL hi_ber_pass k=%0d: got %b want %b", k, out_rx_pass_valid, !exp_hi);
            end
            total++;
            if (out_rx_block_lock !== 1'b1 || out_rx_slip !== 1'b0) begin
               bad++; $display("FAIL hi_ber_lock k=%0d: lock=%b slip=%b want 1 0", k, out_rx_block_lock, out_rx_slip);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_acquire();
      test_unlocked_bad();
      test_back_to_back();
      test_lock_loss();
      test_gaps();
      test_reset_mid();
      test_hi_ber();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
